autotype_sequencer: RTL and testbench

//  Scripted boot-key injector between board buttons and the computer core (orao/UK101).

---
 rtl/autotype_sequencer.sv | 133 +++++++++++++
 tb/tb_autotype_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/autotype_sequencer.sv
// Scripted boot-key injector: replays a fixed sequence of target-reset and key
// presses after reset or on request, merged with the manual buttons.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for auto-start (first clock after reset) or start
// PRESS  | driving the current script entry for PHASE_CYCLES clocks
// GAP    | script outputs released for PHASE_CYCLES clocks
// DONE   | script finished, waiting for start to replay it
module autotype_sequencer #(
    parameter int N_KEYS       = 4,
    parameter int N_STEPS      = 8,
    parameter int PHASE_CYCLES = 2**22,
    parameter logic [N_STEPS*(N_KEYS+2)-1:0] SCRIPT =
        {6'h00, 6'h21, 6'h00, 6'h01, 6'h01, 6'h04, 6'h02, 6'h10},
    parameter bit AUTO_START   = 1'b1,
    parameter bit REPEAT       = 1'b0,
    localparam int SW = (N_STEPS > 1) ? $clog2(N_STEPS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              n_reset_in,
    input  logic [N_KEYS-1:0] keys_in,
    output logic              n_reset_out,
    output logic [N_KEYS-1:0] keys_out,
    output logic              busy,
    output logic              done,
    output logic [SW-1:0]     step
);

    localparam int W  = N_KEYS + 2;
    localparam int TW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(PHASE_CYCLES - 1);
    localparam logic [SW-1:0] STEP_LAST  = SW'(N_STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRESS = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] step_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic          auto_pend;
    logic [W-1:0]  entry, entry_nxt;
    logic          timer_done, last_entry, press_nxt;

    assign entry      = SCRIPT[step*W +: W];
    assign entry_nxt  = SCRIPT[step_nxt*W +: W];
    assign timer_done = (timer == TIMER_LAST);
    assign last_entry = entry[W-1] || (step == STEP_LAST);
    assign press_nxt  = (state_nxt == S_PRESS);

    // Next-state, step and phase-timer logic; abort overrides everything.
    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        timer_nxt = timer;
        case (state)
            S_IDLE: begin
                if ((AUTO_START && auto_pend) || start) begin
                    state_nxt = S_PRESS;
                    step_nxt  = '0;
                    timer_nxt = '0;
                end
            end
            S_PRESS: begin
                if (timer_done) begin
                    state_nxt = S_GAP;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            S_GAP: begin
                if (timer_done) begin
                    timer_nxt = '0;
                    if (last_entry) begin
                        state_nxt = REPEAT ? S_PRESS : S_DONE;
                        step_nxt  = REPEAT ? '0 : step;
                    end else begin
                        state_nxt = S_PRESS;
                        step_nxt  = step + 1'b1;
                    end
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_nxt = S_PRESS;
                    step_nxt  = '0;
                    timer_nxt = '0;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (abort) begin
            state_nxt = S_IDLE;
            step_nxt  = '0;
            timer_nxt = '0;
        end
    end

    // State registers; outputs are registered from next-state values so they
    // line up with the state, and manual inputs appear one clock later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            step        <= '0;
            timer       <= '0;
            auto_pend   <= 1'b1;
            n_reset_out <= 1'b0;
            keys_out    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            step        <= step_nxt;
            timer       <= timer_nxt;
            auto_pend   <= 1'b0;
            n_reset_out <= n_reset_in & ~(press_nxt & entry_nxt[N_KEYS]);
            keys_out    <= keys_in | (press_nxt ? entry_nxt[N_KEYS-1:0] : '0);
            busy        <= (state_nxt == S_PRESS) || (state_nxt == S_GAP);
            done        <= (state_nxt == S_DONE);
        end
    end

endmodule

// File: tb/tb_autotype_sequencer.sv
// Directed bench for autotype_sequencer with PHASE_CYCLES=4: default script with
// auto-start, a looping two-entry script, and a manual-start instance.
module tb_autotype_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // default-script instance
    logic       rst_a = 1'b1, start_a = 1'b0, abort_a = 1'b0, nri_a = 1'b1;
    logic [3:0] kin_a = 4'd0, kout_a;
    logic       nro_a, busy_a, done_a;
    logic [2:0] step_a;

    // repeating instance: entry0 = B, entry1 = C|END
    logic       rst_r = 1'b1;
    logic [3:0] kout_r;
    logic       nro_r, busy_r, done_r;
    logic [2:0] step_r;

    // manual-start instance
    logic       rst_m = 1'b1, start_m = 1'b0, abort_m = 1'b0, nri_m = 1'b1;
    logic [3:0] kin_m = 4'd0, kout_m;
    logic       nro_m, busy_m, done_m;
    logic [2:0] step_m;

    autotype_sequencer #(.PHASE_CYCLES(4)) u_dut (
        .clk(clk), .reset(rst_a), .start(start_a), .abort(abort_a),
        .n_reset_in(nri_a), .keys_in(kin_a), .n_reset_out(nro_a),
        .keys_out(kout_a), .busy(busy_a), .done(done_a), .step(step_a));

    autotype_sequencer #(.PHASE_CYCLES(4), .REPEAT(1'b1),
        .SCRIPT({6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h24, 6'h02})) u_rep (
        .clk(clk), .reset(rst_r), .start(1'b0), .abort(1'b0),
        .n_reset_in(1'b1), .keys_in(4'd0), .n_reset_out(nro_r),
        .keys_out(kout_r), .busy(busy_r), .done(done_r), .step(step_r));

    autotype_sequencer #(.PHASE_CYCLES(4), .AUTO_START(1'b0)) u_man (
        .clk(clk), .reset(rst_m), .start(start_m), .abort(abort_m),
        .n_reset_in(nri_m), .keys_in(kin_m), .n_reset_out(nro_m),
        .keys_out(kout_m), .busy(busy_m), .done(done_m), .step(step_m));

    // Hand-derived key masks of the default script, entries 0..6.
    logic [3:0] exp_keys [7] = '{4'h0, 4'h2, 4'h4, 4'h1, 4'h1, 4'h0, 4'h1};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // e = number of rising edges since the script (re)started, sampled #1 later.
    task automatic check_main(input int e, input logic [3:0] kin);
        int p, ent;
        logic press;
        p     = (e - 1) / 4;
        ent   = p / 2;
        press = (p % 2) == 0;
        if (e >= 57) begin
            check($sformatf("done_nrst e%0d", e), 32'(nro_a), 32'd1);
            check($sformatf("done_keys e%0d", e), 32'(kout_a), 32'(kin));
            check($sformatf("done_busy e%0d", e), 32'(busy_a), 32'd0);
            check($sformatf("done_done e%0d", e), 32'(done_a), 32'd1);
            check($sformatf("done_step e%0d", e), 32'(step_a), 32'd6);
        end else begin
            check($sformatf("run_nrst e%0d", e), 32'(nro_a), (press && ent == 0) ? 32'd0 : 32'd1);
            check($sformatf("run_keys e%0d", e), 32'(kout_a), 32'(kin | (press ? exp_keys[ent] : 4'h0)));
            check($sformatf("run_busy e%0d", e), 32'(busy_a), 32'd1);
            check($sformatf("run_done e%0d", e), 32'(done_a), 32'd0);
            check($sformatf("run_step e%0d", e), 32'(step_a), 32'(ent));
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset values of the default instance
        repeat (3) tick();
        check("rst_nrst", 32'(nro_a), 32'd0);
        check("rst_keys", 32'(kout_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_step", 32'(step_a), 32'd0);

        // full default script with auto-start
        @(negedge clk) rst_a = 1'b0;
        for (int e = 1; e <= 60; e++) begin
            tick();
            check_main(e, 4'h0);
        end
        nri_a = 1'b0;
        tick();
        check("manual_nrst_low", 32'(nro_a), 32'd0);
        nri_a = 1'b1;
        tick();
        check("manual_nrst_high", 32'(nro_a), 32'd1);

        // second run with a held manual key; keys forced low while in reset
        rst_a = 1'b1;
        kin_a = 4'b1000;
        #1;
        check("async_rst_keys", 32'(kout_a), 32'd0);
        check("async_rst_nrst", 32'(nro_a), 32'd0);
        @(negedge clk) rst_a = 1'b0;
        for (int e = 1; e <= 18; e++) begin
            tick();
            check_main(e, 4'b1000);
        end

        // abort during PRESS of entry 2
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        check("abort_keys", 32'(kout_a), 32'h8);
        check("abort_busy", 32'(busy_a), 32'd0);
        check("abort_done", 32'(done_a), 32'd0);
        check("abort_step", 32'(step_a), 32'd0);
        check("abort_nrst", 32'(nro_a), 32'd1);
        repeat (3) begin
            tick();
            check("abort_idle", 32'(busy_a), 32'd0);
        end
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check_main(1, 4'b1000);
        for (int e = 2; e <= 60; e++) begin
            tick();
            check_main(e, 4'b1000);
        end

        // restart from DONE, then reset in the GAP of entry 4
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check_main(1, 4'b1000);
        for (int e = 2; e <= 38; e++) begin
            tick();
            check_main(e, 4'b1000);
        end
        rst_a = 1'b1;
        #1;
        check("midgap_rst_nrst", 32'(nro_a), 32'd0);
        check("midgap_rst_keys", 32'(kout_a), 32'd0);
        check("midgap_rst_busy", 32'(busy_a), 32'd0);
        check("midgap_rst_step", 32'(step_a), 32'd0);
        @(negedge clk) rst_a = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            check_main(e, 4'b1000);
        end

        // repeating two-entry script: period 16 clocks, never done
        @(negedge clk) rst_r = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            int p, st;
            tick();
            p  = (e - 1) / 4;
            st = (p / 2) % 2;
            check($sformatf("rep_step e%0d", e), 32'(step_r), 32'(st));
            check($sformatf("rep_done e%0d", e), 32'(done_r), 32'd0);
            check($sformatf("rep_busy e%0d", e), 32'(busy_r), 32'd1);
            check($sformatf("rep_keys e%0d", e), 32'(kout_r),
                  (p % 2 == 0) ? ((st == 1) ? 32'h4 : 32'h2) : 32'h0);
            check($sformatf("rep_nrst e%0d", e), 32'(nro_r), 32'd1);
        end

        // manual-start instance
        @(negedge clk) rst_m = 1'b0;
        repeat (3) tick();
        check("man_idle_busy", 32'(busy_m), 32'd0);
        check("man_idle_nrst", 32'(nro_m), 32'd1);
        check("man_idle_keys", 32'(kout_m), 32'd0);
        nri_m = 1'b0;
        kin_m = 4'b0100;
        tick();
        check("man_pass_nrst", 32'(nro_m), 32'd0);
        check("man_pass_keys", 32'(kout_m), 32'h4);
        nri_m = 1'b1;
        kin_m = 4'b0000;
        start_m = 1'b1;
        abort_m = 1'b1;
        tick();
        abort_m = 1'b0;
        check("man_abort_wins_busy", 32'(busy_m), 32'd0);
        check("man_abort_wins_nrst", 32'(nro_m), 32'd1);
        tick();
        start_m = 1'b0;
        check("man_start_busy", 32'(busy_m), 32'd1);
        check("man_start_step", 32'(step_m), 32'd0);
        check("man_start_nrst", 32'(nro_m), 32'd0);
        repeat (9) tick();
        check("man_e10_step", 32'(step_m), 32'd1);
        check("man_e10_keys", 32'(kout_m), 32'h2);
        start_m = 1'b1;
        tick();
        start_m = 1'b0;
        check("man_busy_start_step", 32'(step_m), 32'd1);
        check("man_busy_start_keys", 32'(kout_m), 32'h2);
        check("man_busy_start_busy", 32'(busy_m), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
